// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC and issues in-order, pipelined requests to a
// variable-latency instruction memory. Returned words are buffered with their
// PCs in a small FIFO and handed to decode over a valid/ready handshake.
// Redirects from execute flush the buffer and drop responses still in flight.
//
// Ports:
//   clk, n_rst                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        request channel (addr = fetch PC)
//   imem_rsp_valid/data              in-order response channel, never stalled
//   redirect_valid/pc                redirect from execute
//   instr_valid/ready/data/pc        FIFO head towards decode
//   misaligned_fault                 one-cycle pulse after a misaligned redirect
//   inflight                         outstanding requests that will be kept
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              PC_STEP    = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr_data,
    output logic [XLEN-1:0]               instr_pc,
    output logic                          misaligned_fault,
    output logic [$clog2(FIFO_DEPTH):0]   inflight
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 2;
    localparam logic [OW-1:0]   DEPTH_C = OW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

    logic [XLEN-1:0] fetch_pc;
    logic            run;          // holds off the first request for one cycle after reset
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   drop_cnt;
    logic [PW-1:0]   fifo_wr_ptr;
    logic [PW-1:0]   fifo_rd_ptr;
    logic [PW-1:0]   tag_wr_ptr;
    logic [PW-1:0]   tag_rd_ptr;

    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] tag_pc    [FIFO_DEPTH];

    logic [OW-1:0]   occupancy;
    logic            issue;
    logic            rsp_dec;      // response belongs to a live request
    logic            rsp_keep;     // response is written into the FIFO
    logic            rsp_drop;     // response is for a pre-redirect request
    logic            pop;

    // Credit uses registered counts only, so no response input reaches
    // imem_req_valid combinationally.
    assign occupancy      = OW'(fifo_count) + OW'(inflight) + OW'(drop_cnt);
    assign imem_req_valid = run && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    assign rsp_dec  = imem_rsp_valid && (drop_cnt == '0);
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = rsp_dec && !redirect_valid;

    assign instr_valid = (fifo_count != '0);
    assign instr_data  = fifo_data[fifo_rd_ptr];
    assign instr_pc    = fifo_pc[fifo_rd_ptr];
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    // Control state: PC, counters, pointers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run              <= 1'b0;
            fetch_pc         <= RESET_PC;
            inflight         <= '0;
            drop_cnt         <= '0;
            fifo_count       <= '0;
            fifo_wr_ptr      <= '0;
            fifo_rd_ptr      <= '0;
            tag_wr_ptr       <= '0;
            tag_rd_ptr       <= '0;
            misaligned_fault <= 1'b0;
        end else begin
            run              <= 1'b1;
            misaligned_fault <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (issue)
                tag_wr_ptr <= tag_wr_ptr + PW'(1);
            // Every response retires its tag, kept or dropped.
            if (imem_rsp_valid)
                tag_rd_ptr <= tag_rd_ptr + PW'(1);

            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                // Everything still outstanding becomes droppable; a response
                // landing this same cycle is already accounted for.
                drop_cnt    <= drop_cnt + inflight - CW'(imem_rsp_valid);
                inflight    <= '0;
                fifo_count  <= '0;
                fifo_rd_ptr <= fifo_wr_ptr;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + STEP_C;

                if (issue && !rsp_dec)
                    inflight <= inflight + CW'(1);
                else if (!issue && rsp_dec)
                    inflight <= inflight - CW'(1);

                if (rsp_drop)
                    drop_cnt <= drop_cnt - CW'(1);

                if (rsp_keep)
                    fifo_wr_ptr <= fifo_wr_ptr + PW'(1);
                if (pop)
                    fifo_rd_ptr <= fifo_rd_ptr + PW'(1);

                if (rsp_keep && !pop)
                    fifo_count <= fifo_count + CW'(1);
                else if (!rsp_keep && pop)
                    fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Storage: tag queue and instruction buffer, no reset needed
    always_ff @(posedge clk) begin
        if (issue)
            tag_pc[tag_wr_ptr] <= fetch_pc;
        if (rsp_keep) begin
            fifo_data[fifo_wr_ptr] <= imem_rsp_data;
            fifo_pc[fifo_wr_ptr]   <= tag_pc[tag_rd_ptr];
        end
    end

    // A response with nothing outstanding means the memory broke protocol.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!n_rst)
        imem_rsp_valid |-> ((inflight != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        misaligned_fault;
    logic [2:0]  inflight;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .PC_STEP(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .misaligned_fault(misaligned_fault), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } mreq_t;

    // Reference model: memory request queue, buffered count, PC sequences
    mreq_t       mem_q[$];
    int          buf_cnt;
    logic [31:0] req_pc;
    logic [31:0] exp_dec_pc;
    bit          exp_mis;
    bit          started;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int k = 0;
    int first_vld = -1;
    int n_issued = 0;

    // Stimulus knobs
    int          rdy_mode = 1;     // 0: never ready, 1: always, 2: random
    bit          reqr_random = 0;
    bit          rsp_random = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          rnd_redir = 0;
    bit          pend_redir = 0;
    logic [31:0] pend_target = '0;
    bit          want_collide = 0;
    bit          collided = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) n++;
        return n;
    endfunction

    task automatic model_clear();
        mem_q.delete();
        buf_cnt    = 0;
        req_pc     = RST_PC;
        exp_dec_pc = RST_PC;
        exp_mis    = 0;
        started    = 0;
        k          = 0;
        first_vld  = -1;
        n_issued   = 0;
    endtask

    task automatic step();
        bit    do_rsp, do_redir, exp_rv, exp_iv, acc, pop;
        mreq_t m;
        @(negedge clk);
        cyc++;
        do_rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc) &&
                 (!rsp_random || ($urandom_range(0, 3) != 0));
        imem_rsp_valid = do_rsp;
        imem_rsp_data  = do_rsp ? memword(mem_q[0].addr) : $urandom;
        instr_ready    = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        imem_req_ready = reqr_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        do_redir   = pend_redir;
        pend_redir = 0;
        if (want_collide && do_rsp && buf_cnt != 0 && instr_ready) begin
            do_redir     = 1;
            pend_target  = 32'h0000_0300;
            want_collide = 0;
            collided     = 1;
        end
        if (rnd_redir && $urandom_range(0, 19) == 0) begin
            do_redir    = 1;
            pend_target = $urandom & 32'h0000_FFFF;
        end
        redirect_valid = do_redir;
        redirect_pc    = do_redir ? pend_target : $urandom;
        #1;
        exp_rv = started && !do_redir && (buf_cnt + mem_q.size() < DEPTH);
        exp_iv = (buf_cnt != 0);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, req_pc);
        chk("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            chk("instr_pc", instr_pc, exp_dec_pc);
            chk("instr_data", instr_data, memword(exp_dec_pc));
        end
        chk("misaligned", misaligned_fault, exp_mis);
        chk("inflight", inflight, live_cnt());
        if (instr_valid && first_vld < 0) first_vld = k;
        if (imem_req_valid && imem_req_ready) n_issued++;
        k++;

        acc = exp_rv && imem_req_ready;
        pop = exp_iv && instr_ready && !do_redir;
        if (do_redir) begin
            buf_cnt = 0;
            if (do_rsp) m = mem_q.pop_front();
            foreach (mem_q[i]) begin
                m = mem_q[i];
                m.stale = 1;
                mem_q[i] = m;
            end
            req_pc     = {pend_target[31:2], 2'b00};
            exp_dec_pc = req_pc;
            exp_mis    = (pend_target[1:0] != 2'b00);
        end else begin
            exp_mis = 0;
            if (pop) begin
                buf_cnt--;
                exp_dec_pc = exp_dec_pc + 32'd4;
            end
            if (do_rsp) begin
                m = mem_q.pop_front();
                if (!m.stale) buf_cnt++;
            end
            if (acc) begin
                m.addr  = req_pc;
                m.stale = 0;
                m.due   = cyc + $urandom_range(lat_lo, lat_hi);
                mem_q.push_back(m);
                req_pc = req_pc + 32'd4;
            end
        end
        started = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        n_rst          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_misaligned", misaligned_fault, 1'b0);
        chk("rst_inflight", inflight, 3'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_clear();
    endtask

    initial begin
        int  guard;
        model_clear();

        // Streaming at L=1 with decode always ready
        do_reset();
        rdy_mode = 1; lat_lo = 1; lat_hi = 1;
        repeat (20) step();
        chk("first_vld_cycle", first_vld, 3);

        // Back-pressure: buffer fills, then one pop frees exactly one credit
        do_reset();
        rdy_mode = 0;
        repeat (15) step();
        chk("bp_issued", n_issued, 4);
        rdy_mode = 1;
        step();
        rdy_mode = 0;
        n_issued = 0;
        repeat (6) step();
        chk("bp_one_more", n_issued, 1);
        rdy_mode = 1;
        repeat (10) step();

        // Redirect with three live requests in flight at L=3
        lat_lo = 3; lat_hi = 3;
        guard = 0;
        while (live_cnt() != 3 && guard < 50) begin
            step();
            guard++;
        end
        chk("three_inflight", live_cnt(), 3);
        pend_redir = 1; pend_target = 32'h0000_0200;
        repeat (15) step();

        // Misaligned redirect target
        pend_redir = 1; pend_target = 32'h0000_0206;
        repeat (12) step();

        // Redirect colliding with a response and a pop in the same cycle
        lat_lo = 1; lat_hi = 1;
        want_collide = 1;
        guard = 0;
        while (want_collide && guard < 200) begin
            step();
            guard++;
        end
        chk("collide_hit", collided, 1'b1);
        want_collide = 0;
        repeat (12) step();

        // Randomised traffic
        rdy_mode = 2; reqr_random = 1; rsp_random = 1;
        lat_lo = 1; lat_hi = 4; rnd_redir = 1;
        repeat (3000) step();

        // Reset in the middle of operation with a stalled decoder
        rdy_mode = 0; reqr_random = 0; rsp_random = 0;
        lat_lo = 3; lat_hi = 3; rnd_redir = 0;
        repeat (6) step();
        do_reset();
        rdy_mode = 2; reqr_random = 1; rsp_random = 1;
        lat_lo = 1; lat_hi = 4; rnd_redir = 1;
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the core's single-cycle PC register and PC+4 logic.
- Owns the fetch PC and issues in-order, pipelined requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PCs in a FIFO and presents them to decode over a valid/ready handshake.
- Supports redirects (branch, jal, jalr) from execute, including flushing the FIFO and discarding responses still in flight.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 4, instruction buffer entries; also the max in-flight + buffered total; power of two, >= 2
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  request address (= fetch_pc)
imem_rsp_valid  input  1  response valid; in order, at most one per cycle, never back-pressured
imem_rsp_data  input  32  response instruction word
redirect_valid  input  1  redirect request from execute
redirect_pc  input  XLEN  redirect target
instr_valid  output  1  FIFO head valid
instr_ready  input  1  decode consumes head
instr_data  output  32  head instruction
instr_pc  output  XLEN  head PC
misaligned_fault  output  1  one-cycle pulse: redirect target not 4-byte aligned
inflight  output  $clog2(FIFO_DEPTH)+1  outstanding requests not yet returned (debug)

Behaviour:
- Reset values (async, n_rst low):
  - fetch_pc = RESET_PC.
  - FIFO empty; inflight = 0; drop_cnt = 0.
  - imem_req_valid = 0, instr_valid = 0, misaligned_fault = 0.
  - Reset mid-operation discards all state. Later responses for pre-reset requests are the memory's responsibility and are not tolerated.
- Credit rule: imem_req_valid = !redirect_valid && (fifo_count + inflight + drop_cnt < FIFO_DEPTH). This guarantees every accepted response has FIFO space, so a response is never refused.
- Issue: when imem_req_valid && imem_req_ready:
  - fetch_pc += PC_STEP, modulo 2^XLEN.
  - inflight++.
  - The request PC is pushed to an internal pc-tag queue of depth FIFO_DEPTH.
- Response:
  - On imem_rsp_valid with drop_cnt > 0: drop_cnt--, the tag is popped and discarded, and nothing is written to the FIFO.
  - Otherwise: {tag, data} is pushed to the FIFO and inflight--.
  - imem_rsp_valid with nothing outstanding is illegal; assert it in simulation.
- Output:
  - instr_valid = fifo_count != 0.
  - instr_data and instr_pc come combinationally from the FIFO head.
  - The head pops on instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - A response written at edge t is visible at t+1, so minimum request-accept to instr_valid is L+1 cycles for memory latency L.
- Redirect (redirect_valid = 1), with priority over everything that cycle:
  - FIFO is cleared and any pop that cycle is ignored.
  - No request is issued that cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt <= drop_cnt + inflight − (imem_rsp_valid ? 1 : 0), and inflight <= 0. A response arriving in the redirect cycle is discarded.
  - misaligned_fault <= (redirect_pc[1:0] != 0) on the next cycle, as a one-cycle pulse.
  - Back-to-back redirects: each one applies; the last one wins.
- Full: when fifo_count + inflight + drop_cnt == FIFO_DEPTH, no request is issued until a pop or a dropped response frees a slot. A freed slot lets a request issue in the following cycle, since the credit is computed from registered counts.
- No combinational path from imem_rsp_* to imem_req_valid. The only combinational input to imem_req_valid is redirect_valid.

Test Plan:
- Reset to RESET_PC=0x100, memory L=1, instr_ready=1 → requests 0x100, 0x104, 0x108…, one per cycle; instr_pc/instr_data stream in order; first instr_valid at cycle 3 after reset release.
- Backpressure: instr_ready=0, FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; raising instr_ready for 1 cycle → exactly one new request; data order preserved.
- Redirect with 3 in flight (L=3) to 0x200 → FIFO flushed, 3 responses dropped (drop_cnt 3→0), next instr_pc=0x200; no stale PC is ever presented.
- Redirect in the same cycle as a response and an instr_valid && instr_ready pop → the pop is ignored, the response is discarded, drop_cnt = inflight−1, and the restart from the target is clean.
- Redirect to 0x206 → misaligned_fault pulses 1 cycle, fetch resumes at 0x204.
- n_rst asserted with a full FIFO and 2 in flight → all outputs reset immediately; after release, fetch restarts at RESET_PC with inflight=0.
